led_slot_decoder: RTL



---
 rtl/led_slot_decoder.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/led_slot_decoder.sv
// led_slot_decoder: scans 12 LED-code slots into a one-hot shadow frame
// and commits each finished frame atomically; optional LED_SLOT_ERR_EN.
module led_slot_decoder #(
   parameter int SCAN_DIV = 50
) (
   input  logic        CLOCK_50,
   input  logic        resetn,
   input  logic        enable,
   input  logic [3:0]  LEDnum1,
   input  logic [3:0]  LEDnum2,
   input  logic [3:0]  LEDnum3,
   input  logic [3:0]  LEDnum4,
   input  logic [3:0]  LEDnum5,
   input  logic [3:0]  LEDnum6,
   input  logic [3:0]  LEDnum7,
   input  logic [3:0]  LEDnum8,
   input  logic [3:0]  LEDnum9,
   input  logic [3:0]  LEDnum10,
   input  logic [3:0]  LEDnum11,
   input  logic [3:0]  LEDnum12,
   output logic [11:0] led,
   output logic        frame_done,
   output logic        err
);

   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [3:0] IDX_LAST = 4'd11;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SCAN   = 2'd1;
   localparam logic [1:0] S_COMMIT = 2'd2;

   logic [1:0]    state;
   logic [3:0]    idx;
   logic [DW-1:0] div;
   logic [11:0]   shadow;
   logic [3:0]    code;
   logic          code_ok;
   logic [11:0]   code_bit;
   logic          sample;

   // select the slot addressed by the current scan index
   always_comb begin
      code = 4'd0;
      case (idx)
         4'd0:    code = LEDnum1;
         4'd1:    code = LEDnum2;
         4'd2:    code = LEDnum3;
         4'd3:    code = LEDnum4;
         4'd4:    code = LEDnum5;
         4'd5:    code = LEDnum6;
         4'd6:    code = LEDnum7;
         4'd7:    code = LEDnum8;
         4'd8:    code = LEDnum9;
         4'd9:    code = LEDnum10;
         4'd10:   code = LEDnum11;
         4'd11:   code = LEDnum12;
         default: code = 4'd0;
      endcase
   end

   // decode the selected code to a one-hot LED bit; 0 and 13..15 light nothing
   always_comb begin
      code_ok  = (code != 4'd0) && (code <= 4'd12);
      code_bit = 12'd0;
      if (code_ok)
         code_bit = 12'd1 << (code - 4'd1);
      sample = (state == S_SCAN) && enable && (div == DIV_LAST);
   end

   // scan sequencer, shadow accumulation and atomic frame commit
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state      <= S_IDLE;
         idx        <= 4'd0;
         div        <= '0;
         shadow     <= 12'd0;
         led        <= 12'd0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (enable) begin
                  state  <= S_SCAN;
                  idx    <= 4'd0;
                  div    <= '0;
                  shadow <= 12'd0;
               end
            end
            S_SCAN: begin
               if (!enable) begin
                  // abort: partial frame is thrown away, led keeps last frame
                  state  <= S_IDLE;
                  idx    <= 4'd0;
                  div    <= '0;
                  shadow <= 12'd0;
               end else if (div == DIV_LAST) begin
                  shadow <= shadow | code_bit;
                  div    <= '0;
                  if (idx == IDX_LAST) begin
                     state <= S_COMMIT;
                     idx   <= 4'd0;
                  end else begin
                     idx <= idx + 4'd1;
                  end
               end else begin
                  div <= div + 1'b1;
               end
            end
            S_COMMIT: begin
               led        <= shadow;
               frame_done <= 1'b1;
               shadow     <= 12'd0;
               idx        <= 4'd0;
               div        <= '0;
               state      <= enable ? S_SCAN : S_IDLE;
            end
            default: begin
               state  <= S_IDLE;
               idx    <= 4'd0;
               div    <= '0;
               shadow <= 12'd0;
            end
         endcase
      end
   end

`ifdef LED_SLOT_ERR_EN
   logic code_bad;

   // codes 13..15 at a sample point are illegal on the bus
   always_comb code_bad = (code > 4'd12);

   // sticky error flag, cleared only by reset
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn)
         err <= 1'b0;
      else if (sample && code_bad)
         err <= 1'b1;
   end
`else
   logic unused_sample;

   assign unused_sample = sample;
   assign err = 1'b0;
`endif

endmodule
